mem_sequencer: RTL and testbench
================================

Name: mem_sequencer

Overview:
Multi-cycle sequencer for the unpipelined Beta datapath. It shares one single-port memory between instruction fetch and LD/ST data access, and holds the instruction register for the CU. It gates state commit (PC load, register-file write) and schedules IRQ entry at instruction boundaries, so the CU decodes from a stable INSTR and IRQ.

Parameters:
ADDR_W, 16, memory word-address width; MEM_ADDR = byte address bits [ADDR_W+1:2].
TIMEOUT, 255, max cycles to wait for MEM_ACK before a bus error; counter width $clog2(TIMEOUT+1).

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
IRQ  in  1  external interrupt request, level, synchronous to CLK
PC  in  32  current PC; PC[31] = supervisor bit
MA  in  32  data address from ALU output
MWD  in  32  store data (RD2)
MOE  in  1  CU load request, sampled in DECODE
MWR  in  1  CU store request, sampled in DECODE
MEM_RD  in  32  memory read data, valid with MEM_ACK
MEM_ACK  in  1  memory completion strobe
MEM_ADDR  out  ADDR_W  word address to memory
MEM_RE  out  1  read request
MEM_WE  out  1  write request
MEM_WD  out  32  write data
INSTR  out  32  instruction register to CU
RDATA  out  32  latched load data to WDSEL mux
IRQ_CU  out  1  interrupt-taken flag to CU
COMMIT  out  1  one-cycle enable for PC register and WERF
BUS_ERR  out  1  sticky timeout flag

Behaviour:
- Reset (async): state=BOOT; INSTR=0, RDATA=0, IRQ_CU=0, COMMIT=0, BUS_ERR=0, MEM_RE/MEM_WE=0, MEM_ADDR=0, MEM_WD=0, irq_pend=0, timer=0. Requests drop immediately, including mid-transaction.
- States: BOOT, FETCH, DECODE, DATA, COMMIT_S.
- BOOT: one cycle, then FETCH.
- FETCH entry decision (registered on the transition into FETCH):
  - If irq_pend & ~PC[31]: skip the memory read, set IRQ_CU=1, clear irq_pend, go to DECODE.
  - Else assert MEM_RE with MEM_ADDR=PC[ADDR_W+1:2].
  - On MEM_ACK: INSTR<=MEM_RD, go to DECODE. A same-cycle ACK is legal, so a zero-wait fetch takes 1 cycle.
- DECODE: one cycle; CU outputs settle.
  - IRQ_CU=1: go to COMMIT_S.
  - Else MOE|MWR: go to DATA, latching MEM_ADDR=MA[ADDR_W+1:2], MEM_WD=MWD, op=MWR. MWR takes precedence if both are set.
  - Else: go to COMMIT_S.
- DATA: MEM_WE=op, MEM_RE=~op, with address and data held stable. On MEM_ACK: a read latches RDATA<=MEM_RD; go to COMMIT_S.
- COMMIT_S: COMMIT=1 for exactly one cycle; IRQ_CU clears at exit; go to FETCH.
- IRQ latching: irq_pend set on any cycle IRQ=1.
  - IRQ rising in the same cycle as the FETCH-entry decision is seen the next boundary.
  - irq_pend persists while PC[31]=1 (supervisor) and while an instruction is in flight.
- Timeout: timer counts cycles in FETCH/DATA without MEM_ACK and resets on state entry. At timer==TIMEOUT:
  - BUS_ERR<=1 (sticky until RESET); request dropped.
  - FETCH: INSTR<=32'h0 (illegal opcode → CU ILLOP path), go to DECODE.
  - DATA: go to COMMIT_S with RDATA unchanged.
- MEM_ACK outside FETCH/DATA is ignored.
- Latency with zero-wait memory: non-memory op = 3 cycles (FETCH, DECODE, COMMIT_S); LD/ST = 4; interrupt entry = 2 (DECODE, COMMIT_S).
- MEM_RE and MEM_WE are never both 1. Outputs are registered except MEM_RE/MEM_WE, which are decoded from state only (no input-to-output combinational path).

Decomposition:
- Shared package beta_pkg:
  - state encoding localparams (BOOT=3'd0, FETCH=3'd1, DECODE=3'd2, DATA=3'd3, COMMIT_S=3'd4)
  - ILLOP_INSTR=32'h0
  - SUPERVISOR_BIT=31
- Natural sub-module: mem_timeout_ctr (load/clear, count, expire pulse), parameterised by TIMEOUT.

Test Plan:
- RESET=1 mid-DATA with MEM_WE=1 → MEM_WE=0 within the same cycle, COMMIT=0; after release, BOOT→FETCH with MEM_ADDR=PC[17:2].
- PC=32'h0000_0040, MEM_RD=32'h8022_0800 with same-cycle ACK, MOE=MWR=0 → MEM_ADDR=16'h0010, INSTR=32'h8022_0800, COMMIT high on cycle 3 only.
- LD: MOE=1, MA=32'h0000_0100, memory ACKs after 2 wait cycles with 32'hDEAD_BEEF → MEM_RE held on address 16'h0040 for 3 cycles, RDATA=32'hDEAD_BEEF, single COMMIT pulse.
- ST: MWR=1, MA=32'h0000_0200, MWD=32'h1234_5678 → MEM_WE=1, MEM_ADDR=16'h0080, MEM_WD=32'h1234_5678, MEM_RE=0 throughout.
- IRQ pulsed for 1 cycle while PC=32'h8000_0010 → no IRQ_CU; then PC=32'h0000_0010 at the next boundary → IRQ_CU=1, no MEM_RE that instruction, COMMIT after 2 cycles, irq_pend cleared.
- MEM_ACK never asserted in FETCH, TIMEOUT=4 → MEM_RE dropped after 4 cycles, BUS_ERR=1 (stays 1), INSTR=0, sequence proceeds to DECODE then COMMIT_S.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared definitions for the Beta multi-cycle sequencer: state encoding and
// fixed instruction/PC constants used by the memory sequencer.
package beta_pkg;

  typedef logic [2:0] state_t;

  localparam state_t BOOT     = 3'd0;
  localparam state_t FETCH    = 3'd1;
  localparam state_t DECODE   = 3'd2;
  localparam state_t DATA     = 3'd3;
  localparam state_t COMMIT_S = 3'd4;

  // All-zero word decodes as an illegal opcode, steering the CU to ILLOP.
  localparam logic [31:0] ILLOP_INSTR = 32'h0000_0000;

  localparam int SUPERVISOR_BIT = 31;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for a pending memory request; pulses expire_o on the
// TIMEOUT-th consecutive cycle without an acknowledge.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry on the cycle that would bring the count to TIMEOUT.
  assign expire_o = count_i & (cnt_q == LAST);

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle sequencer for the unpipelined Beta: shares one memory port
// between fetch and LD/ST, holds INSTR, gates COMMIT and schedules IRQ entry.
module mem_sequencer
  import beta_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IRQ,
  input  logic [31:0]       PC,
  input  logic [31:0]       MA,
  input  logic [31:0]       MWD,
  input  logic              MOE,
  input  logic              MWR,
  input  logic [31:0]       MEM_RD,
  input  logic              MEM_ACK,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RE,
  output logic              MEM_WE,
  output logic [31:0]       MEM_WD,
  output logic [31:0]       INSTR,
  output logic [31:0]       RDATA,
  output logic              IRQ_CU,
  output logic              COMMIT,
  output logic              BUS_ERR
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              op_q, op_d;
  logic              irq_pend_q, irq_pend_d;
  logic              irq_cu_q, irq_cu_d;
  logic              commit_q, commit_d;
  logic              bus_err_q, bus_err_d;

  logic at_boundary, irq_take, mem_active, expire;
  logic unused_bits;

  assign unused_bits = ^{PC[30:ADDR_W+2], PC[1:0], MA[31:ADDR_W+2], MA[1:0]};

  // The next clock edge out of BOOT/COMMIT_S is the instruction boundary.
  assign at_boundary = (state_q == BOOT) || (state_q == COMMIT_S);
  assign irq_take    = at_boundary & irq_pend_q & ~PC[SUPERVISOR_BIT];
  assign mem_active  = (state_q == FETCH) || (state_q == DATA);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .clear_i  (state_d != state_q),
    .count_i  (mem_active & ~MEM_ACK),
    .expire_o (expire)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT, COMMIT_S: state_d = irq_take ? DECODE : FETCH;
      FETCH: begin
        if (MEM_ACK || expire) state_d = DECODE;
      end
      DECODE: begin
        if (irq_cu_q)        state_d = COMMIT_S;
        else if (MOE || MWR) state_d = DATA;
        else                 state_d = COMMIT_S;
      end
      DATA: begin
        if (MEM_ACK || expire) state_d = COMMIT_S;
      end
      default: state_d = BOOT;
    endcase
  end

  // Requests depend on state and the latched op only, never on inputs.
  always_comb begin
    MEM_RE = (state_q == FETCH) || ((state_q == DATA) && !op_q);
    MEM_WE = (state_q == DATA) && op_q;
  end

  always_comb begin
    addr_d     = addr_q;
    wd_d       = wd_q;
    op_d       = op_q;
    instr_d    = instr_q;
    rdata_d    = rdata_q;
    irq_cu_d   = irq_cu_q;
    irq_pend_d = IRQ | (irq_pend_q & ~irq_take);
    bus_err_d  = bus_err_q | expire;
    commit_d   = (state_d == COMMIT_S);

    if (at_boundary) begin
      if (irq_take) begin
        irq_cu_d = 1'b1;
      end else begin
        irq_cu_d = 1'b0;
        addr_d   = PC[ADDR_W+1:2];
      end
    end

    if (state_q == FETCH) begin
      if (MEM_ACK)     instr_d = MEM_RD;
      else if (expire) instr_d = ILLOP_INSTR;
    end

    if ((state_q == DECODE) && !irq_cu_q && (MOE || MWR)) begin
      addr_d = MA[ADDR_W+1:2];
      wd_d   = MWD;
      op_d   = MWR;
    end

    if ((state_q == DATA) && MEM_ACK && !op_q) begin
      rdata_d = MEM_RD;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q     <= '0;
      wd_q       <= '0;
      op_q       <= 1'b0;
      instr_q    <= '0;
      rdata_q    <= '0;
      irq_pend_q <= 1'b0;
      irq_cu_q   <= 1'b0;
      commit_q   <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      op_q       <= op_d;
      instr_q    <= instr_d;
      rdata_q    <= rdata_d;
      irq_pend_q <= irq_pend_d;
      irq_cu_q   <= irq_cu_d;
      commit_q   <= commit_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign MEM_ADDR = addr_q;
  assign MEM_WD   = wd_q;
  assign INSTR    = instr_q;
  assign RDATA    = rdata_q;
  assign IRQ_CU   = irq_cu_q;
  assign COMMIT   = commit_q;
  assign BUS_ERR  = bus_err_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: table of single-instruction transactions
// plus hand-built IRQ-scheduling and reset-mid-store sequences.
module tb_mem_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IRQ = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] MA = '0;
  logic [31:0] MWD = '0;
  logic        MOE = 1'b0;
  logic        MWR = 1'b0;
  logic [31:0] MEM_RD = '0;
  logic        MEM_ACK = 1'b0;
  logic [15:0] MEM_ADDR;
  logic        MEM_RE, MEM_WE;
  logic [31:0] MEM_WD, INSTR, RDATA;
  logic        IRQ_CU, COMMIT, BUS_ERR;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_sequencer #(.ADDR_W(16), .TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .PC(PC), .MA(MA), .MWD(MWD),
    .MOE(MOE), .MWR(MWR), .MEM_RD(MEM_RD), .MEM_ACK(MEM_ACK),
    .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_WD(MEM_WD),
    .INSTR(INSTR), .RDATA(RDATA), .IRQ_CU(IRQ_CU), .COMMIT(COMMIT), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc, ma, mwd;
    logic        moe, mwr;
    logic [31:0] minstr, mdata;
    logic        fnoack;
    int          dwait;
    logic        irq_pulse;
    int          exp_cyc;
    logic [15:0] exp_faddr, exp_daddr;
    int          exp_re, exp_we;
    logic [31:0] exp_wd, exp_instr, exp_rdata;
    logic        exp_berr, exp_irq;
  } vec_t;

  function automatic vec_t mk(
    input logic [31:0] pc, ma, mwd, input logic moe, mwr,
    input logic [31:0] minstr, mdata, input logic fnoack, input int dwait,
    input logic irq_pulse, input int exp_cyc, input logic [15:0] exp_faddr, exp_daddr,
    input int exp_re, exp_we, input logic [31:0] exp_wd, exp_instr, exp_rdata,
    input logic exp_berr, exp_irq);
    vec_t v;
    v.pc = pc; v.ma = ma; v.mwd = mwd; v.moe = moe; v.mwr = mwr;
    v.minstr = minstr; v.mdata = mdata; v.fnoack = fnoack; v.dwait = dwait;
    v.irq_pulse = irq_pulse; v.exp_cyc = exp_cyc; v.exp_faddr = exp_faddr;
    v.exp_daddr = exp_daddr; v.exp_re = exp_re; v.exp_we = exp_we; v.exp_wd = exp_wd;
    v.exp_instr = exp_instr; v.exp_rdata = exp_rdata; v.exp_berr = exp_berr;
    v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one instruction from a boundary (BOOT/COMMIT_S about to exit) to its
  // COMMIT cycle, acting as the memory, then checks what was observed.
  task automatic apply(input vec_t v, input string tag);
    int cyc = 0, re_n = 0, we_n = 0, dcnt = 0, commit_cyc = 0;
    logic fetched = 1'b0, irq_seen = 1'b0, overlap = 1'b0, unstable = 1'b0;
    logic [15:0] faddr = '0, daddr = '0;
    logic [31:0] wd = '0;
    PC = v.pc; MA = v.ma; MWD = v.mwd; MOE = v.moe; MWR = v.mwr;
    IRQ = v.irq_pulse; MEM_ACK = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      IRQ = 1'b0; MEM_ACK = 1'b0; cyc++;
      if (MEM_RE && MEM_WE) overlap = 1'b1;
      if (IRQ_CU) irq_seen = 1'b1;
      if (COMMIT) begin commit_cyc = cyc; break; end
      if (MEM_RE && !fetched) begin
        if (re_n == 0) faddr = MEM_ADDR;
        re_n++;
        if (!v.fnoack) begin MEM_ACK = 1'b1; MEM_RD = v.minstr; fetched = 1'b1; end
      end else if (MEM_RE || MEM_WE) begin
        if (MEM_RE) re_n++; else we_n++;
        if (dcnt == 0) begin daddr = MEM_ADDR; wd = MEM_WD; end
        else if (MEM_ADDR !== daddr || MEM_WD !== wd) unstable = 1'b1;
        if (dcnt == v.dwait) begin MEM_ACK = 1'b1; MEM_RD = v.mdata; end
        dcnt++;
      end
    end
    chk({tag, " commit_cycle"}, 32'(commit_cyc), 32'(v.exp_cyc));
    chk({tag, " re_cycles"}, 32'(re_n), 32'(v.exp_re));
    chk({tag, " we_cycles"}, 32'(we_n), 32'(v.exp_we));
    if (v.exp_re > 0) chk({tag, " fetch_addr"}, 32'(faddr), 32'(v.exp_faddr));
    if (v.moe || v.mwr) begin
      chk({tag, " data_addr"}, 32'(daddr), 32'(v.exp_daddr));
      chk({tag, " data_stable"}, 32'(unstable), 32'd0);
    end
    if (v.exp_we > 0) chk({tag, " mem_wd"}, wd, v.exp_wd);
    chk({tag, " instr"}, INSTR, v.exp_instr);
    chk({tag, " rdata"}, RDATA, v.exp_rdata);
    chk({tag, " bus_err"}, 32'(BUS_ERR), 32'(v.exp_berr));
    chk({tag, " irq_cu"}, 32'(irq_seen), 32'(v.exp_irq));
    chk({tag, " re_we_overlap"}, 32'(overlap), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    //             pc             ma             mwd           moe  mwr  minstr         mdata          fna  dw  irq cyc faddr     daddr     re we wd             instr          rdata          be   irq
    vecs[0] = mk(32'h0000_0040, 32'h0,         32'h0,         1'b0,1'b0,32'h8022_0800, 32'h0,         1'b0,0, 1'b0,3, 16'h0010, 16'h0,    1, 0, 32'h0,         32'h8022_0800, 32'h0,         1'b0,1'b0);
    vecs[1] = mk(32'h0000_0044, 32'h0000_0100, 32'h0,         1'b1,1'b0,32'h6000_0100, 32'hDEAD_BEEF, 1'b0,2, 1'b0,6, 16'h0011, 16'h0040, 4, 0, 32'h0,         32'h6000_0100, 32'hDEAD_BEEF, 1'b0,1'b0);
    vecs[2] = mk(32'h0000_0048, 32'h0000_0200, 32'h1234_5678, 1'b0,1'b1,32'h6400_0200, 32'h1111_1111, 1'b0,0, 1'b0,4, 16'h0012, 16'h0080, 1, 1, 32'h1234_5678, 32'h6400_0200, 32'hDEAD_BEEF, 1'b0,1'b0);
    vecs[3] = mk(32'h0000_004C, 32'h0000_0300, 32'hCAFE_F00D, 1'b1,1'b1,32'h6400_0300, 32'h2222_2222, 1'b0,1, 1'b0,5, 16'h0013, 16'h00C0, 1, 2, 32'hCAFE_F00D, 32'h6400_0300, 32'hDEAD_BEEF, 1'b0,1'b0);
    vecs[4] = mk(32'h0001_0000, 32'hFFFF_FFFC, 32'h0,         1'b1,1'b0,32'h6000_FFFC, 32'h0BAD_F00D, 1'b0,0, 1'b0,4, 16'h4000, 16'hFFFF, 2, 0, 32'h0,         32'h6000_FFFC, 32'h0BAD_F00D, 1'b0,1'b0);
    vecs[5] = mk(32'h8003_FFFC, 32'h0,         32'h0,         1'b0,1'b0,32'h8000_0000, 32'h0,         1'b0,0, 1'b0,3, 16'hFFFF, 16'h0,    1, 0, 32'h0,         32'h8000_0000, 32'h0BAD_F00D, 1'b0,1'b0);
    vecs[6] = mk(32'h0000_0050, 32'h0,         32'h0,         1'b0,1'b0,32'hFFFF_FFFF, 32'h0,         1'b1,0, 1'b0,6, 16'h0014, 16'h0,    4, 0, 32'h0,         32'h0000_0000, 32'h0BAD_F00D, 1'b1,1'b0);
    vecs[7] = mk(32'h0000_0054, 32'h0000_0400, 32'h0,         1'b1,1'b0,32'h6000_0400, 32'h3333_3333, 1'b0,99,1'b0,7, 16'h0015, 16'h0100, 5, 0, 32'h0,         32'h6000_0400, 32'h0BAD_F00D, 1'b1,1'b0);
    vecs[8] = mk(32'h0000_0058, 32'h0,         32'h0,         1'b0,1'b0,32'h8000_1234, 32'h0,         1'b0,0, 1'b0,3, 16'h0016, 16'h0,    1, 0, 32'h0,         32'h8000_1234, 32'h0BAD_F00D, 1'b1,1'b0);

    repeat (2) @(posedge CLK);
    #1;
    chk("reset mem_re", 32'(MEM_RE), 32'd0);
    chk("reset mem_we", 32'(MEM_WE), 32'd0);
    chk("reset mem_addr", 32'(MEM_ADDR), 32'd0);
    chk("reset mem_wd", MEM_WD, 32'd0);
    chk("reset instr", INSTR, 32'd0);
    chk("reset rdata", RDATA, 32'd0);
    chk("reset irq_cu", 32'(IRQ_CU), 32'd0);
    chk("reset commit", 32'(COMMIT), 32'd0);
    chk("reset bus_err", 32'(BUS_ERR), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 9; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // IRQ held off in supervisor mode, taken at the first user-mode boundary.
    apply(mk(32'h8000_0010, 0, 0, 1'b0, 1'b0, 32'h7000_0010, 0, 1'b0, 0, 1'b1, 3, 16'h0004, 0, 1, 0, 0, 32'h7000_0010, 32'h0BAD_F00D, 1'b1, 1'b0), "irq_sup1");
    apply(mk(32'h8000_0014, 0, 0, 1'b0, 1'b0, 32'h7000_0014, 0, 1'b0, 0, 1'b0, 3, 16'h0005, 0, 1, 0, 0, 32'h7000_0014, 32'h0BAD_F00D, 1'b1, 1'b0), "irq_sup2");
    apply(mk(32'h0000_0010, 0, 0, 1'b0, 1'b0, 32'hEEEE_EEEE, 0, 1'b0, 0, 1'b0, 2, 16'h0,    0, 0, 0, 0, 32'h7000_0014, 32'h0BAD_F00D, 1'b1, 1'b1), "irq_take1");
    apply(mk(32'h0000_0010, 0, 0, 1'b0, 1'b0, 32'h7100_0010, 0, 1'b0, 0, 1'b0, 3, 16'h0004, 0, 1, 0, 0, 32'h7100_0010, 32'h0BAD_F00D, 1'b1, 1'b0), "irq_after1");
    // IRQ arriving in the boundary cycle itself waits for the following one.
    apply(mk(32'h0000_0020, 0, 0, 1'b0, 1'b0, 32'h7200_0020, 0, 1'b0, 0, 1'b1, 3, 16'h0008, 0, 1, 0, 0, 32'h7200_0020, 32'h0BAD_F00D, 1'b1, 1'b0), "irq_late");
    apply(mk(32'h0000_0024, 0, 0, 1'b0, 1'b0, 32'hEEEE_EEEE, 0, 1'b0, 0, 1'b0, 2, 16'h0,    0, 0, 0, 0, 32'h7200_0020, 32'h0BAD_F00D, 1'b1, 1'b1), "irq_take2");
    apply(mk(32'h0000_0024, 0, 0, 1'b0, 1'b0, 32'h7300_0024, 0, 1'b0, 0, 1'b0, 3, 16'h0009, 0, 1, 0, 0, 32'h7300_0024, 32'h0BAD_F00D, 1'b1, 1'b0), "irq_after2");

    // Reset asserted in the middle of a stalled store.
    PC = 32'h0000_0060; MOE = 1'b0; MWR = 1'b1; MA = 32'h0000_0200; MWD = 32'hA5A5_A5A5;
    @(posedge CLK); #1;
    MEM_ACK = 1'b1; MEM_RD = 32'h6400_0200;
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
    @(posedge CLK); #1;
    chk("rst_mid mem_we_before", 32'(MEM_WE), 32'd1);
    chk("rst_mid mem_addr_before", 32'(MEM_ADDR), 32'h0080);
    RESET = 1'b1;
    #1;
    chk("rst_mid mem_we", 32'(MEM_WE), 32'd0);
    chk("rst_mid mem_re", 32'(MEM_RE), 32'd0);
    chk("rst_mid commit", 32'(COMMIT), 32'd0);
    chk("rst_mid bus_err", 32'(BUS_ERR), 32'd0);
    chk("rst_mid rdata", RDATA, 32'd0);
    @(negedge CLK);
    RESET = 1'b0; MWR = 1'b0;
    apply(mk(32'h0002_0044, 0, 0, 1'b0, 1'b0, 32'h5555_0044, 0, 1'b0, 0, 1'b0, 3, 16'h8011, 0, 1, 0, 0, 32'h5555_0044, 32'h0, 1'b0, 1'b0), "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
